// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: issue/result bundle between the EX stage and the
// iterative multiply/divide unit.
//   master (EX stage)  drives start, op, rs_val, rt_val, flush;
//                      observes busy, stall, result, hi_out, lo_out.
//   slave  (unit)      the reverse.
interface muldiv_unit_if #(
  parameter int unsigned DATA_W = 32
);
  logic              start;
  logic [2:0]        op;
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;
  logic              flush;
  logic              busy;
  logic              stall;
  logic [DATA_W-1:0] result;
  logic [DATA_W-1:0] hi_out;
  logic [DATA_W-1:0] lo_out;

  modport master (
    output start, op, rs_val, rt_val, flush,
    input  busy, stall, result, hi_out, lo_out
  );

  modport slave (
    input  start, op, rs_val, rt_val, flush,
    output busy, stall, result, hi_out, lo_out
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 multiply/divide unit with the architectural
// HI/LO registers (MULT/MULTU/DIV/DIVU, MFHI/MFLO/MTHI/MTLO).
//   clock  : rising-edge clock
//   reset  : synchronous, active-low
//   bus    : muldiv_unit_if.slave
//            start/op/rs_val/rt_val/flush in;
//            busy (op in flight), stall (= busy & start),
//            result (MFHI/MFLO read data), hi_out/lo_out (HI/LO) out.
// A mul/div is accepted in IDLE, runs DATA_W iteration cycles on operand
// magnitudes, then one fix-up cycle applies signs and writes HI/LO.
module muldiv_unit #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 6
) (
  input logic          clock,
  input logic          reset,
  muldiv_unit_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ITER,
    ST_FIX
  } state_e;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MFHI  = 3'd4,
    OP_MFLO  = 3'd5,
    OP_MTHI  = 3'd6,
    OP_MTLO  = 3'd7
  } op_e;

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

  state_e              state, state_nxt;
  logic [CNT_W-1:0]    count, count_nxt;
  logic [2*DATA_W-1:0] acc, acc_nxt;      // mul: {partial, multiplier}; div: {remainder, quotient}
  logic [DATA_W-1:0]   opnd, opnd_nxt;    // multiplicand or divisor magnitude
  logic [DATA_W-1:0]   hi, hi_nxt;
  logic [DATA_W-1:0]   lo, lo_nxt;
  logic                is_div, is_div_nxt;
  logic                neg_q, neg_q_nxt;  // negate product / quotient in FIX
  logic                neg_r, neg_r_nxt;  // negate remainder in FIX
  logic                div_zero, div_zero_nxt;

  op_e               op;
  logic              is_signed;
  logic [DATA_W-1:0] mag_rs, mag_rt;

  assign op        = op_e'(bus.op);
  assign is_signed = (op == OP_MULT) || (op == OP_DIV);
  assign mag_rs    = (is_signed && bus.rs_val[DATA_W-1]) ? -bus.rs_val : bus.rs_val;
  assign mag_rt    = (is_signed && bus.rt_val[DATA_W-1]) ? -bus.rt_val : bus.rt_val;

  // One iteration step of each algorithm.
  logic [DATA_W:0]     mul_sum;
  logic [DATA_W:0]     rem_sh;
  logic [DATA_W:0]     trial;
  logic [2*DATA_W-1:0] mul_step, div_step, prod_fix;

  assign mul_sum  = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, opnd} : '0);
  assign mul_step = {mul_sum, acc[DATA_W-1:1]};
  assign rem_sh   = acc[2*DATA_W-1:DATA_W-1];
  assign trial    = rem_sh - {1'b0, opnd};
  assign div_step = trial[DATA_W] ? {rem_sh[DATA_W-1:0], acc[DATA_W-2:0], 1'b0}
                                  : {trial[DATA_W-1:0],  acc[DATA_W-2:0], 1'b1};
  assign prod_fix = neg_q ? -acc : acc;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= ST_IDLE;
      count    <= '0;
      acc      <= '0;
      opnd     <= '0;
      hi       <= '0;
      lo       <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      state    <= state_nxt;
      count    <= count_nxt;
      acc      <= acc_nxt;
      opnd     <= opnd_nxt;
      hi       <= hi_nxt;
      lo       <= lo_nxt;
      is_div   <= is_div_nxt;
      neg_q    <= neg_q_nxt;
      neg_r    <= neg_r_nxt;
      div_zero <= div_zero_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    count_nxt    = count;
    acc_nxt      = acc;
    opnd_nxt     = opnd;
    hi_nxt       = hi;
    lo_nxt       = lo;
    is_div_nxt   = is_div;
    neg_q_nxt    = neg_q;
    neg_r_nxt    = neg_r;
    div_zero_nxt = div_zero;

    case (state)
      ST_IDLE: begin
        if (bus.start && !bus.flush) begin
          case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              is_div_nxt   = bus.op[1];
              neg_q_nxt    = is_signed && (bus.rs_val[DATA_W-1] ^ bus.rt_val[DATA_W-1]);
              neg_r_nxt    = is_signed && bus.rs_val[DATA_W-1];
              div_zero_nxt = bus.op[1] && (bus.rt_val == '0);
              count_nxt    = '0;
              state_nxt    = ST_ITER;
              if (bus.op[1]) begin
                acc_nxt  = {{DATA_W{1'b0}}, mag_rs};
                opnd_nxt = mag_rt;
              end else begin
                acc_nxt  = {{DATA_W{1'b0}}, mag_rt};
                opnd_nxt = mag_rs;
              end
            end
            OP_MTHI: hi_nxt = bus.rs_val;
            OP_MTLO: lo_nxt = bus.rs_val;
            default: ;
          endcase
        end
      end

      ST_ITER: begin
        if (bus.flush) begin
          state_nxt = ST_IDLE;
        end else begin
          acc_nxt   = is_div ? div_step : mul_step;
          count_nxt = count + 1'b1;
          if (count == LAST_STEP) state_nxt = ST_FIX;
        end
      end

      ST_FIX: begin
        state_nxt = ST_IDLE;
        if (!bus.flush) begin
          if (is_div) begin
            // A zero divisor leaves quotient all ones and remainder = |rs|;
            // skipping quotient negation and keeping the remainder sign
            // reproduces the raw dividend in HI for both DIV and DIVU.
            lo_nxt = (neg_q && !div_zero) ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
            hi_nxt = neg_r ? -acc[2*DATA_W-1:DATA_W] : acc[2*DATA_W-1:DATA_W];
          end else begin
            hi_nxt = prod_fix[2*DATA_W-1:DATA_W];
            lo_nxt = prod_fix[DATA_W-1:0];
          end
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.busy   = (state != ST_IDLE);
    bus.stall  = bus.busy && bus.start;
    bus.result = '0;
    if (state == ST_IDLE && bus.start) begin
      if (op == OP_MFHI)      bus.result = hi;
      else if (op == OP_MFLO) bus.result = lo;
    end
  end

  assign bus.hi_out = hi;
  assign bus.lo_out = lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: self-checking bench for muldiv_unit. Directed scenarios
// plus a randomized back-to-back run, checked against an arithmetic model
// of HI/LO built from the instruction semantics.
module tb_muldiv_unit;

  localparam int unsigned W = 32;
  localparam int unsigned N_RAND = 30;

  logic clock;
  logic reset;

  muldiv_unit_if #(.DATA_W(W)) bus ();

  muldiv_unit #(.DATA_W(W), .CNT_W(6)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] hi_m;
  logic [31:0] lo_m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Instruction-level reference: plain signed/unsigned arithmetic.
  function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, p, q, r;
    logic [63:0] u;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    case (o)
      3'd0: begin p = sa * sb; hi_m = p[63:32]; lo_m = p[31:0]; end
      3'd1: begin u = {32'b0, a} * {32'b0, b}; hi_m = u[63:32]; lo_m = u[31:0]; end
      3'd2, 3'd3: begin
        if (b == 32'd0) begin
          lo_m = 32'hFFFF_FFFF;
          hi_m = a;
        end else if (o == 3'd2) begin
          q = sa / sb; r = sa % sb;
          lo_m = q[31:0]; hi_m = r[31:0];
        end else begin
          lo_m = a / b; hi_m = a % b;
        end
      end
      3'd6: hi_m = a;
      3'd7: lo_m = a;
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return 32'($urandom());
    endcase
  endfunction

  // Issue a mul/div (caller sits just after a negedge, unit idle or about
  // to go idle). Right after acceptance the inputs switch to the "next"
  // instruction, which is held while busy and is accepted once idle.
  task automatic exec(input string tag, input logic [2:0] o, input logic [31:0] a,
                      input logic [31:0] b, input logic nxt_start,
                      input logic [2:0] nxt_op, input logic [31:0] na, input logic [31:0] nb);
    int cnt;
    logic [31:0] exp_res;
    bus.start = 1'b1; bus.op = o; bus.rs_val = a; bus.rt_val = b;
    @(posedge clock); #1;
    bus.start = nxt_start; bus.op = nxt_op; bus.rs_val = na; bus.rt_val = nb;
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (!bus.busy) break;
      cnt++;
      check({tag, " stall"}, 32'(bus.stall), 32'(nxt_start));
    end
    check({tag, " busy_len"}, 32'(cnt), 32'd33);
    model(o, a, b);
    check({tag, " hi"}, bus.hi_out, hi_m);
    check({tag, " lo"}, bus.lo_out, lo_m);
    if (nxt_start) begin
      exp_res = (nxt_op == 3'd4) ? hi_m : (nxt_op == 3'd5) ? lo_m : 32'd0;
      check({tag, " result"}, bus.result, exp_res);
    end
  endtask

  // Start an op, raise flush after wait_n negedges, confirm HI/LO survive.
  task automatic abort(input string tag, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input int wait_n);
    bus.start = 1'b1; bus.op = o; bus.rs_val = a; bus.rt_val = b;
    @(posedge clock); #1;
    bus.start = 1'b0;
    repeat (wait_n) @(negedge clock);
    check({tag, " busy_before"}, 32'(bus.busy), 32'd1);
    bus.flush = 1'b1;
    @(posedge clock); #1;
    bus.flush = 1'b0;
    @(negedge clock);
    check({tag, " busy_after"}, 32'(bus.busy), 32'd0);
    check({tag, " hi"}, bus.hi_out, hi_m);
    check({tag, " lo"}, bus.lo_out, lo_m);
  endtask

  task automatic mt(input logic [2:0] o, input logic [31:0] a);
    bus.start = 1'b1; bus.op = o; bus.rs_val = a;
    @(posedge clock); #1;
    bus.start = 1'b0;
    model(o, a, 32'd0);
    @(negedge clock);
  endtask

  logic [2:0]  r_op [N_RAND];
  logic [31:0] r_a  [N_RAND];
  logic [31:0] r_b  [N_RAND];

  initial begin
    bus.start = 1'b0; bus.flush = 1'b0; bus.op = 3'd0;
    bus.rs_val = '0; bus.rt_val = '0;
    hi_m = '0; lo_m = '0;
    reset = 1'b0;

    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst busy",   32'(bus.busy),  32'd0);
    check("rst stall",  32'(bus.stall), 32'd0);
    check("rst result", bus.result,     32'd0);
    check("rst hi",     bus.hi_out,     32'd0);
    check("rst lo",     bus.lo_out,     32'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);

    // MULT -3 x 7
    exec("mult_neg", 3'd0, 32'hFFFF_FFFD, 32'd7, 1'b0, 3'd0, 32'd0, 32'd0);
    check("mult_neg const hi", bus.hi_out, 32'hFFFF_FFFF);
    check("mult_neg const lo", bus.lo_out, 32'hFFFF_FFEB);

    // MULTU max x max, then DIV -7/2 held and accepted back-to-back
    exec("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 3'd2, 32'hFFFF_FFF9, 32'd2);
    check("multu_max const hi", bus.hi_out, 32'hFFFF_FFFE);
    check("multu_max const lo", bus.lo_out, 32'h0000_0001);
    exec("div_m7_2", 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 3'd0, 32'd0, 32'd0);
    check("div_m7_2 const lo", bus.lo_out, 32'hFFFF_FFFD);
    check("div_m7_2 const hi", bus.hi_out, 32'hFFFF_FFFF);

    // Signed overflow, then DIVU by zero
    exec("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 3'd3, 32'd10, 32'd0);
    check("div_ovf const lo", bus.lo_out, 32'h8000_0000);
    check("div_ovf const hi", bus.hi_out, 32'd0);
    exec("divu_z", 3'd3, 32'd10, 32'd0, 1'b0, 3'd0, 32'd0, 32'd0);
    check("divu_z const lo", bus.lo_out, 32'hFFFF_FFFF);
    check("divu_z const hi", bus.hi_out, 32'h0000_000A);
    exec("div_z_neg", 3'd2, 32'hFFFF_FFF0, 32'd0, 1'b0, 3'd0, 32'd0, 32'd0);

    // MTLO then MFLO the next cycle
    bus.start = 1'b1; bus.op = 3'd7; bus.rs_val = 32'h1234_5678;
    @(negedge clock);
    check("mtlo busy", 32'(bus.busy), 32'd0);
    @(posedge clock); #1;
    model(3'd7, 32'h1234_5678, 32'd0);
    bus.op = 3'd5;
    @(negedge clock);
    check("mflo busy",   32'(bus.busy),  32'd0);
    check("mflo stall",  32'(bus.stall), 32'd0);
    check("mflo result", bus.result,     32'h1234_5678);
    @(posedge clock); #1;
    bus.start = 1'b0;
    @(negedge clock);
    check("mflo idle result", bus.result, 32'd0);

    // MFHI held behind a MULT
    exec("mult_mfhi", 3'd0, 32'h0001_2345, 32'hFFF0_0001, 1'b1, 3'd4, 32'd0, 32'd0);
    bus.start = 1'b0;

    // Reset in the middle of ITER
    bus.start = 1'b1; bus.op = 3'd0; bus.rs_val = 32'd5; bus.rt_val = 32'd5;
    @(posedge clock); #1;
    bus.start = 1'b0;
    repeat (11) @(negedge clock);
    check("rst_mid busy_before", 32'(bus.busy), 32'd1);
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    hi_m = '0; lo_m = '0;
    @(negedge clock);
    check("rst_mid busy", 32'(bus.busy), 32'd0);
    check("rst_mid hi",   bus.hi_out,    32'd0);
    check("rst_mid lo",   bus.lo_out,    32'd0);
    exec("mult_5x5", 3'd0, 32'd5, 32'd5, 1'b0, 3'd0, 32'd0, 32'd0);
    check("mult_5x5 const lo", bus.lo_out, 32'd25);

    // Flush: during ITER and during FIX, with HI=1, LO=2 preloaded
    mt(3'd6, 32'd1);
    mt(3'd7, 32'd2);
    abort("flush_iter", 3'd0, 32'd9, 32'd9, 10);
    check("flush_iter const hi", bus.hi_out, 32'd1);
    check("flush_iter const lo", bus.lo_out, 32'd2);
    abort("flush_fix", 3'd3, 32'd100, 32'd7, 33);

    // start with flush in IDLE is ignored
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = 3'd6; bus.rs_val = 32'hDEAD_BEEF;
    @(posedge clock); #1;
    bus.op = 3'd0;
    @(posedge clock); #1;
    bus.start = 1'b0; bus.flush = 1'b0;
    @(negedge clock);
    check("idle_flush busy", 32'(bus.busy), 32'd0);
    check("idle_flush hi",   bus.hi_out,    hi_m);

    // Randomized back-to-back stream
    for (int i = 0; i < int'(N_RAND); i++) begin
      r_op[i] = 3'($urandom_range(0, 3));
      r_a[i]  = pick();
      r_b[i]  = pick();
    end
    for (int i = 0; i < int'(N_RAND); i++) begin
      if (i + 1 < int'(N_RAND))
        exec("rand", r_op[i], r_a[i], r_b[i], 1'b1, r_op[i+1], r_a[i+1], r_b[i+1]);
      else
        exec("rand", r_op[i], r_a[i], r_b[i], 1'b0, 3'd0, 32'd0, 32'd0);
    end
    for (int i = 0; i < 4; i++) begin
      abort("rand_flush", 3'($urandom_range(0, 3)), pick(), pick(), $urandom_range(1, 33));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit in the EX stage. It consumes the operand values and the decoded mul/div op issued from the ID/EX pipeline register.
- It owns the architectural HI/LO registers and serves MFHI/MFLO/MTHI/MTLO.
- It drives a stall request back to hazard control, which deasserts ID/EX wen and holds the issuing instruction while a multi-cycle operation is in flight.

Parameters:
- DATA_W, 32: operand, HI and LO width.
- CNT_W, 6: iteration counter width; must satisfy 2^CNT_W > DATA_W.

Ports:
- clock, in, 1: rising-edge clock.
- reset, in, 1: synchronous, active-low reset.
- start, in, 1: a mul/div-class instruction is present in EX this cycle.
- op, in, 3: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MFHI, 5 MFLO, 6 MTHI, 7 MTLO.
- rs_val, in, DATA_W: rs operand (multiplicand / dividend / MTHI/MTLO source).
- rt_val, in, DATA_W: rt operand (multiplier / divisor).
- flush, in, 1: abort any in-flight operation; also blocks acceptance of start this cycle.
- busy, out, 1: iterative operation in flight.
- stall, out, 1: request to hold ID/EX and upstream stages.
- result, out, DATA_W: MFHI/MFLO read data.
- hi_out, out, DATA_W: current HI register.
- lo_out, out, DATA_W: current LO register.

Behaviour:
- Reset (reset==0 at an edge):
  - state goes to IDLE; hi, lo, counter and internal accumulators all clear to 0.
  - busy=0, stall=0, result=0.
  - Reset has priority over flush and start, including mid-operation.
- State machine has three states: IDLE, ITER, FIX.
- Acceptance in IDLE:
  - A start with op 0-3 and flush==0 is accepted at that edge (E0). Go to ITER with count=0.
  - Latch |rs| and |rt| for signed ops, raw values for unsigned ops.
  - Latch sign flags: product/quotient sign = rs[msb]^rt[msb]; remainder sign = rs[msb].
- ITER state:
  - One radix-2 step per cycle.
  - Multiply is shift-add over a 2*DATA_W accumulator.
  - Divide is restoring: shift the remainder left, trial-subtract the divisor, set the quotient bit if non-negative.
  - After DATA_W steps (edges E1..E32) go to FIX.
- FIX state (edge E33):
  - Apply sign correction by two's-complement negation where the sign flag is set (signed ops only).
  - Write HI/LO: multiply gives HI=product[63:32], LO=product[31:0]; divide gives LO=quotient, HI=remainder.
  - Return to IDLE.
- Timing:
  - busy=1 in the cycles between E0 and E33, i.e. exactly DATA_W+1 = 33 cycles.
  - The new HI/LO is visible on hi_out/lo_out in the first cycle after E33.
- Divide by zero: detected at E0; latency stays fixed. Result is LO=all ones, HI=rs_val (raw dividend), for both DIV and DIVU.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0. This falls out of unsigned-magnitude arithmetic with no special case.
- stall = busy & start. This covers any mul/div-class op arriving while busy, including MFHI/MFLO/MTHI/MTLO, which must wait for completion.
- Held instruction: it keeps start asserted; it is accepted in the first cycle where busy==0.
- Back-to-back: a new op is accepted in the cycle after E33, with zero idle bubble.
- MTHI / MTLO:
  - Accepted only in IDLE with flush==0.
  - Write rs_val into HI (MTHI) or LO (MTLO) at that edge; one cycle; busy stays 0.
- MFHI / MFLO:
  - result is combinational: hi for MFHI, lo for MFLO, when state==IDLE and start==1; 0 otherwise.
  - Never stalls in IDLE.
- start with flush==1 in IDLE: ignored; no state change.
- Flush in ITER or FIX: return to IDLE at that edge; HI/LO are unchanged (the aborted result is discarded); busy=0 next cycle.
- start asserted while busy with flush==0: no side effects; the operands are not re-latched.

Test Plan:
- MULT rs=0xFFFFFFFD (-3), rt=7:
  - Requires busy high for exactly 33 cycles.
  - Then HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF:
  - Requires HI=0xFFFFFFFE, LO=0x00000001.
  - Then DIV -7/2 issued back-to-back is accepted in the cycle after completion and gives LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF:
  - Requires LO=0x80000000, HI=0.
  - Then DIVU 10/0 requires LO=0xFFFFFFFF, HI=0x0000000A after 33 busy cycles.
- MTLO 0x12345678 then MFLO in the next cycle:
  - result=0x12345678, busy never asserts.
  - Then MFHI held on start during a MULT: stall=1 for all busy cycles; after completion, result equals the new HI.
- MULT 5x5 with reset driven low at cycle 10 of ITER:
  - Requires busy=0, HI=LO=0 after that edge.
  - A new MULT after reset releases completes correctly.
  - With HI=1, LO=2 preloaded: flush during ITER must leave HI=1, LO=2 and busy=0 on the following cycle.
